// File: rtl/vblank_arbiter.sv
// Round-robin arbiter granting each requester at most once per vertical-blanking interval.
// Define VBLANK_ARB_TIMEOUT_EN to revoke grants held longer than MAX_HOLD cycles.
module vblank_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vblnk,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             frame_tick,
    output logic             overrun,
    output logic             timeout
);
    localparam int PW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 2) begin : g_illegal_params
        $error("vblank_arbiter: N_REQ must be 2..8 and MAX_HOLD at least 2");
    end

    typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

    state_t           state_reg, state_next;
    logic             vblnk_q;
    logic [N_REQ-1:0] served_reg, served_next;
    logic [PW-1:0]    ptr_reg, ptr_next;
    logic [N_REQ-1:0] grant_next;
    logic             frame_tick_next, overrun_next;

    logic             rise, fall;
    logic [N_REQ-1:0] cand, cand_rot;
    logic [PW-1:0]    rot_idx [N_REQ];
    logic             found;
    logic [PW-1:0]    pick;
    logic             release_now, revoke_now;

    assign rise = vblnk & ~vblnk_q;
    assign fall = ~vblnk & vblnk_q;
    assign cand = req & ~served_reg;

    // Rotated view of the candidates: slot gi holds requester (ptr+1+gi) mod N_REQ.
    genvar gi;
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
        logic [PW:0] sum;
        assign sum = {1'b0, ptr_reg} + (PW+1)'(gi + 1);
        assign rot_idx[gi] = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : PW'(sum);
        assign cand_rot[gi] = cand[rot_idx[gi]];
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_rot[i]) begin
                found = 1'b1;
                pick  = rot_idx[i];
            end
        end
    end

    // While granting, ptr_reg still names the granted requester.
    assign release_now = (state_reg == GRANT) && (done[ptr_reg] || !req[ptr_reg]);

`ifdef VBLANK_ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_reg, hold_next;
    logic          hold_expired;
    logic          timeout_reg;

    assign hold_expired = (hold_reg == HW'(MAX_HOLD - 1));
    // A normal release on the same edge wins over the forced revoke.
    assign revoke_now   = (state_reg == GRANT) && !release_now && hold_expired;

    always_comb begin
        hold_next = hold_reg;
        if (state_reg == ARB && found) begin
            hold_next = '0;
        end else if (state_reg == GRANT && !release_now && !hold_expired) begin
            hold_next = hold_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            hold_reg    <= hold_next;
            timeout_reg <= revoke_now;
        end
    end

    assign timeout = timeout_reg;
`else
    assign revoke_now = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        served_next     = served_reg;
        ptr_next        = ptr_reg;
        grant_next      = grant;
        frame_tick_next = 1'b0;
        overrun_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rise) begin
                    frame_tick_next = 1'b1;
                    served_next     = '0;
                    state_next      = ARB;
                end
            end
            ARB: begin
                if (found) begin
                    grant_next        = N_REQ'(1) << pick;
                    ptr_next          = pick;
                    served_next[pick] = 1'b1;
                    state_next        = GRANT;
                end else if (!vblnk) begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                // Blanking ending mid-grant is only flagged; the grant runs to release.
                overrun_next = fall;
                if (release_now || revoke_now) begin
                    grant_next = '0;
                    state_next = vblnk ? ARB : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            vblnk_q    <= 1'b0;
            served_reg <= '0;
            ptr_reg    <= PW'(N_REQ - 1);
            grant      <= '0;
            busy       <= 1'b0;
            frame_tick <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            vblnk_q    <= vblnk;
            served_reg <= served_next;
            ptr_reg    <= ptr_next;
            grant      <= grant_next;
            busy       <= |grant_next;
            frame_tick <= frame_tick_next;
            overrun    <= overrun_next;
        end
    end
endmodule
